// File: rtl/clk_gate_multi.sv
// rtl/clk_gate_multi.sv - multi-channel glitch-free clock gate with per-channel hold-off
//
// Purpose:
//   NUM_CH independent clock gates. Each channel keeps its clock running for
//   HOLD_CYCLES extra cycles after its enable drops. This absorbs short idle gaps
//   without toggling the gate. test_en_i forces every gate open.
//
// Ports:
//   clk_i      in   1       free-running source clock
//   arst_ni    in   1       asynchronous active-low reset
//   en_i       in   NUM_CH  per-channel enable, synchronous to clk_i
//   test_en_i  in   1       forces every gate open, synchronous to clk_i
//   clk_o      out  NUM_CH  gated clocks
//   ack_o      out  NUM_CH  1 = gate currently open (latched gate enable)

`timescale 1ns/1ps

module clk_gate_multi #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              test_en_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] ack_o
);

  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_ON   = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] open_d;
  logic [NUM_CH-1:0] latch_q;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        S_OFF: begin
          if (en_i[c]) state_d[c] = S_ON;
        end
        S_ON: begin
          if (!en_i[c]) begin
            if (HOLD_CYCLES > 0) begin
              state_d[c] = S_HOLD;
              cnt_d[c]   = CNT_W'(HOLD_CYCLES);
            end else begin
              state_d[c] = S_OFF;
            end
          end
        end
        S_HOLD: begin
          if (en_i[c]) begin
            state_d[c] = S_ON;
            cnt_d[c]   = '0;
          end else begin
            // cnt reaches 0 on the same edge the gate request drops
            cnt_d[c] = cnt_q[c] - CNT_W'(1);
            if (cnt_q[c] == CNT_W'(1)) state_d[c] = S_OFF;
          end
        end
        default: begin
          state_d[c] = S_OFF;
          cnt_d[c]   = '0;
        end
      endcase
      open_d[c] = (state_q[c] != S_OFF) | test_en_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!arst_ni) begin
        state_q[c] <= S_OFF;
        cnt_q[c]   <= '0;
      end else begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  // Gate enable is captured while clk_i is low, so the AND below can only
  // open or close during the low phase: no runt pulses. Reset closes it at once.
  always_ff @(negedge clk_i or negedge arst_ni) begin
    if (!arst_ni) latch_q <= '0;
    else          latch_q <= open_d;
  end

  assign clk_o = {NUM_CH{clk_i}} & latch_q;
  assign ack_o = latch_q;

endmodule

// File: tb/tb_clk_gate_multi.sv
// tb/tb_clk_gate_multi.sv - self-checking bench for clk_gate_multi (HOLD_CYCLES 0 and 3)

`timescale 1ns/1ps

module tb_clk_gate_multi;

  localparam int HALF = 5;
  localparam int BIG  = 1000;

  logic       clk    = 1'b0;
  logic       arst_n = 1'b0;
  logic       ten    = 1'b0;
  logic [3:0] en0    = 4'h0;
  logic [3:0] en3    = 4'h0;
  logic [3:0] clk_o0, ack_o0, clk_o3, ack_o3;

  int checks   = 0;
  int failures = 0;

  always #HALF clk = ~clk;

  clk_gate_multi #(.NUM_CH(4), .HOLD_CYCLES(0)) u_h0 (
    .clk_i(clk), .arst_ni(arst_n), .en_i(en0), .test_en_i(ten),
    .clk_o(clk_o0), .ack_o(ack_o0)
  );

  clk_gate_multi #(.NUM_CH(4), .HOLD_CYCLES(3)) u_h3 (
    .clk_i(clk), .arst_ni(arst_n), .en_i(en3), .test_en_i(ten),
    .clk_o(clk_o3), .ack_o(ack_o3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a gate is open for the cycle after posedge k when en was
  // sampled high at some posedge within the last HOLD_CYCLES+1 edges since reset.
  int         age0 [4] = '{BIG, BIG, BIG, BIG};
  int         age3 [4] = '{BIG, BIG, BIG, BIG};
  logic [3:0] exp_lat0 = 4'h0;
  logic [3:0] exp_lat3 = 4'h0;
  int         exp_cnt0 [4] = '{0, 0, 0, 0};
  int         exp_cnt3 [4] = '{0, 0, 0, 0};

  always @(posedge clk or negedge arst_n) begin
    for (int c = 0; c < 4; c++) begin
      if (!arst_n) begin
        age0[c] <= BIG;
        age3[c] <= BIG;
      end else begin
        age0[c] <= en0[c] ? 0 : ((age0[c] < BIG) ? age0[c] + 1 : BIG);
        age3[c] <= en3[c] ? 0 : ((age3[c] < BIG) ? age3[c] + 1 : BIG);
      end
    end
  end

  always @(negedge clk or negedge arst_n) begin
    for (int c = 0; c < 4; c++) begin
      if (!arst_n) begin
        exp_lat0[c] <= 1'b0;
        exp_lat3[c] <= 1'b0;
      end else begin
        exp_lat0[c] <= (age0[c] <= 0) | ten;
        exp_lat3[c] <= (age3[c] <= 3) | ten;
      end
    end
  end

  always @(posedge clk) begin
    if (arst_n) begin
      for (int c = 0; c < 4; c++) begin
        exp_cnt0[c] <= exp_cnt0[c] + int'(exp_lat0[c]);
        exp_cnt3[c] <= exp_cnt3[c] + int'(exp_lat3[c]);
      end
    end
  end

  // Edge monitors: count real clk_o pulses, every full pulse must be a whole
  // half period wide, and the gate may only move while clk is low.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    int      n0 = 0;
    int      n3 = 0;
    realtime r0 = 0.0;
    realtime r3 = 0.0;
    always @(posedge clk_o0[g]) begin n0++; r0 = $realtime; end
    always @(posedge clk_o3[g]) begin n3++; r3 = $realtime; end
    always @(negedge clk_o0[g]) if (arst_n) chk($sformatf("width0[%0d]", g), int'($realtime - r0), HALF);
    always @(negedge clk_o3[g]) if (arst_n) chk($sformatf("width3[%0d]", g), int'($realtime - r3), HALF);
  end

  always @(ack_o0 or ack_o3) if (arst_n) chk("gate_moved_while_clk_high", {31'd0, clk}, 0);

  typedef struct {
    logic [3:0] en0;
    logic [3:0] en3;
    logic       ten;
    logic [3:0] a0;
    logic [3:0] a3;
  } vec_t;

  vec_t tbl [17];
  int   cnt;

  initial begin
    tbl[0]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{4'h1, 4'h2, 1'b0, 4'h1, 4'h2};
    tbl[2]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h2};
    tbl[3]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h2};
    tbl[4]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h2};
    tbl[5]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[6]  = '{4'h0, 4'h4, 1'b0, 4'h0, 4'h4};
    tbl[7]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h4};
    tbl[8]  = '{4'h0, 4'h4, 1'b0, 4'h0, 4'h4};
    tbl[9]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h4};
    tbl[10] = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h4};
    tbl[11] = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h4};
    tbl[12] = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[13] = '{4'h0, 4'h0, 1'b1, 4'hF, 4'hF};
    tbl[14] = '{4'hA, 4'h8, 1'b0, 4'hA, 4'h8};
    tbl[15] = '{4'hF, 4'h0, 1'b0, 4'hF, 4'h8};
    tbl[16] = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h8};

    // Reset held with all enables high: everything closed
    en0 = 4'hF; en3 = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_clk_o0", clk_o0, 0); chk("rst_clk_o3", clk_o3, 0);
      chk("rst_ack_o0", ack_o0, 0); chk("rst_ack_o3", ack_o3, 0);
    end
    en0 = 4'h0; en3 = 4'h0;
    @(negedge clk); #2 arst_n = 1'b1;

    // Table: inputs set in the low phase, ack checked after the next negedge
    for (int i = 0; i < 17; i++) begin
      en0 = tbl[i].en0; en3 = tbl[i].en3; ten = tbl[i].ten;
      @(posedge clk); @(negedge clk); #1;
      chk($sformatf("tbl%0d_ack0", i), ack_o0, tbl[i].a0);
      chk($sformatf("tbl%0d_ack3", i), ack_o3, tbl[i].a3);
    end
    en0 = 4'h0; en3 = 4'h0;
    repeat (5) @(posedge clk);

    // Reset asserted in the middle of a high phase truncates the pulse
    #1 en0 = 4'hF; en3 = 4'hF;
    repeat (3) @(posedge clk);
    #2 chk("open_before_rst0", clk_o0, 4'hF); chk("open_before_rst3", clk_o3, 4'hF);
    arst_n = 1'b0;
    #1 chk("midhigh_rst_clk_o0", clk_o0, 0); chk("midhigh_rst_clk_o3", clk_o3, 0);
    en0 = 4'h0; en3 = 4'h0;
    @(negedge clk); #2 arst_n = 1'b1;
    @(negedge clk); #1 chk("closed_after_release0", ack_o0, 0); chk("closed_after_release3", ack_o3, 0);

    // HOLD_CYCLES=0: one-cycle enable gives exactly one pulse, only on ch0
    @(posedge clk); #1 en0 = 4'h1;
    @(posedge clk); #1 en0 = 4'h0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      cnt += int'(clk_o0[0]);
      chk("h0_others_silent", {clk_o0[3:1], clk_o3}, 0);
    end
    chk("h0_single_pulse", cnt, 1);

    // HOLD_CYCLES=3: enable drops, pulses continue for three more edges
    @(posedge clk); #1 en3 = 4'h2;
    repeat (3) @(posedge clk);
    #1 en3 = 4'h0;
    @(posedge clk); #1 chk("h3_pulse_at_drop", clk_o3[1], 1);
    cnt = 0;
    repeat (3) begin @(posedge clk); #1 cnt += int'(clk_o3[1]); end
    chk("h3_ack_before_close", ack_o3[1], 1);
    @(negedge clk); #1 chk("h3_ack_closed", ack_o3[1], 0);
    repeat (3) begin @(posedge clk); #1 cnt += int'(clk_o3[1]); end
    chk("h3_hold_pulses", cnt, 3);

    // HOLD_CYCLES=3: re-assert during hold keeps the clock continuous
    @(posedge clk); #1 en3 = 4'h4;
    repeat (3) @(posedge clk);
    #1 en3 = 4'h0;
    cnt = 0;
    repeat (2) begin @(posedge clk); #1 cnt += int'(clk_o3[2]); end
    en3 = 4'h4;
    repeat (8) begin @(posedge clk); #1 cnt += int'(clk_o3[2]); end
    chk("h3_reassert_no_gap", cnt, 10);
    en3 = 4'h0;
    repeat (6) @(posedge clk);

    // Test bypass opens all gates; releasing it closes them at the next negedge
    #1 ten = 1'b1;
    @(posedge clk); #1;
    chk("test_clk_o0_high", clk_o0, 4'hF); chk("test_clk_o3_high", clk_o3, 4'hF);
    chk("test_ack0", ack_o0, 4'hF); chk("test_ack3", ack_o3, 4'hF);
    @(negedge clk); #1 chk("test_clk_o0_low", clk_o0, 0); chk("test_clk_o3_low", clk_o3, 0);
    @(posedge clk); #1 ten = 1'b0;
    @(negedge clk); #1 chk("test_release0", ack_o0, 0); chk("test_release3", ack_o3, 0);

    // Random enables, test bypass and resets against the reference model
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      chk("rnd_ack0", ack_o0, exp_lat0);
      chk("rnd_ack3", ack_o3, exp_lat3);
      en0 ^= 4'($urandom & $urandom);
      en3 ^= 4'($urandom & $urandom & $urandom);
      ten  = ($urandom_range(0, 19) == 0);
      @(negedge clk); #2;
      if (arst_n && $urandom_range(0, 99) == 0) arst_n = 1'b0;
      else if (!arst_n && $urandom_range(0, 2) == 0) arst_n = 1'b1;
    end
    arst_n = 1'b1; en0 = 4'h0; en3 = 4'h0; ten = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pulses0_ch0", g_mon[0].n0, exp_cnt0[0]); chk("pulses3_ch0", g_mon[0].n3, exp_cnt3[0]);
    chk("pulses0_ch1", g_mon[1].n0, exp_cnt0[1]); chk("pulses3_ch1", g_mon[1].n3, exp_cnt3[1]);
    chk("pulses0_ch2", g_mon[2].n0, exp_cnt0[2]); chk("pulses3_ch2", g_mon[2].n3, exp_cnt3[2]);
    chk("pulses0_ch3", g_mon[3].n0, exp_cnt0[3]); chk("pulses3_ch3", g_mon[3].n3, exp_cnt3[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
